// File: rtl/wb_uart_tx_arb.sv
// wb_uart_tx_arb: round-robin packet arbiter sharing one UART TX core
// between N_REQ byte-stream requesters, with busy and lock supervision.
module wb_uart_tx_arb #(
  parameter int N_REQ    = 4,
  parameter int BUSY_TMO = 16,
  parameter int LOCK_TMO = 1024
) (
  input  logic               i_clk,
  input  logic               i_arst_n,
  input  logic [N_REQ-1:0]   iv_req_valid,
  input  logic [8*N_REQ-1:0] iv_req_data,
  input  logic [N_REQ-1:0]   iv_req_last,
  output logic [N_REQ-1:0]   ov_req_ack,
  output logic               o_utx_start,
  output logic [7:0]         ov_utx_data,
  input  logic               i_utx_busy,
  output logic [N_REQ-1:0]   ov_grant,
  output logic               o_locked,
  output logic               o_busy_tmo,
  output logic               o_lock_drop
);

  localparam int PW = $clog2(N_REQ);
  localparam int BW = $clog2(BUSY_TMO + 1);
  localparam int LW = $clog2(LOCK_TMO + 1);

  localparam logic [BW-1:0] BUSY_END = BW'(BUSY_TMO - 1);
  localparam logic [LW-1:0] LOCK_END = LW'(LOCK_TMO - 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(N_REQ - 1);
  localparam logic [PW:0]   N_WIDE   = (PW+1)'(N_REQ);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_HI,
    WAIT_LO
  } state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   owner;
  logic [PW-1:0]   owner_nxt;
  logic [PW-1:0]   pick;
  logic [PW:0]     sum;
  logic            found;
  logic [BW-1:0]   busy_tmr;
  logic [LW-1:0]   lock_tmr;
  logic            last_q;
  logic [7:0]      own_data;
  logic [7:0]      pick_data;
  logic [N_REQ-1:0] pick_oh;

  assign owner_nxt = (owner == LAST_IDX) ? '0 : owner + 1'b1;
  assign own_data  = iv_req_data[8*int'(owner) +: 8];
  assign pick_data = iv_req_data[8*int'(pick) +: 8];
  assign pick_oh   = N_REQ'(1) << pick;

  // first valid requester at or above the pointer, wrapping around
  always_comb begin
    pick  = '0;
    found = 1'b0;
    sum   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + (PW+1)'(i);
      if (sum >= N_WIDE) sum = sum - N_WIDE;
      if (iv_req_valid[sum[PW-1:0]]) begin
        pick  = sum[PW-1:0];
        found = 1'b1;
      end
    end
  end

  // transmit sequencer, lock ownership and fault supervision
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      owner       <= '0;
      busy_tmr    <= '0;
      lock_tmr    <= '0;
      last_q      <= 1'b0;
      ov_req_ack  <= '0;
      o_utx_start <= 1'b0;
      ov_utx_data <= '0;
      ov_grant    <= '0;
      o_locked    <= 1'b0;
      o_busy_tmo  <= 1'b0;
      o_lock_drop <= 1'b0;
    end else begin
      o_utx_start <= 1'b0;
      ov_req_ack  <= '0;
      o_busy_tmo  <= 1'b0;
      o_lock_drop <= 1'b0;
      unique case (state)
        IDLE: begin
          if (o_locked) begin
            if (iv_req_valid[owner]) begin
              lock_tmr <= '0;
              if (!i_utx_busy) begin
                ov_utx_data <= own_data;
                last_q      <= iv_req_last[owner];
                o_utx_start <= 1'b1;
                ov_req_ack  <= ov_grant;
                state       <= START;
              end
            end else if (lock_tmr == LOCK_END) begin
              o_locked    <= 1'b0;
              ov_grant    <= '0;
              o_lock_drop <= 1'b1;
              ptr         <= owner_nxt;
              lock_tmr    <= '0;
            end else begin
              lock_tmr <= lock_tmr + 1'b1;
            end
          end else if (!i_utx_busy && found) begin
            owner       <= pick;
            ov_grant    <= pick_oh;
            o_locked    <= 1'b1;
            ov_utx_data <= pick_data;
            last_q      <= iv_req_last[pick];
            o_utx_start <= 1'b1;
            ov_req_ack  <= pick_oh;
            lock_tmr    <= '0;
            state       <= START;
          end
        end
        START: begin
          busy_tmr <= '0;
          state    <= WAIT_HI;
        end
        WAIT_HI: begin
          if (i_utx_busy) begin
            state <= WAIT_LO;
          end else if (busy_tmr == BUSY_END) begin
            o_busy_tmo <= 1'b1;
            o_locked   <= 1'b0;
            ov_grant   <= '0;
            ptr        <= owner_nxt;
            state      <= IDLE;
          end else begin
            busy_tmr <= busy_tmr + 1'b1;
          end
        end
        WAIT_LO: begin
          if (!i_utx_busy) begin
            state <= IDLE;
            if (last_q) begin
              o_locked <= 1'b0;
              ov_grant <= '0;
              ptr      <= owner_nxt;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/wb_uart_tx_arb.md
Name: wb_uart_tx_arb

Overview:
- Shares the single UART transmitter (start pulse, byte data, busy status) between N_REQ on-chip byte-stream requesters.
- Arbitration is round-robin at packet granularity: once granted, a requester owns the TX until its byte flagged last has finished transmitting.
- Sits between the requesters and the UART TX core, in parallel with the WB UART slave's TX path.
- Also supervises the busy handshake and drops stalled owners, reporting both faults as pulses.

Parameters:
N_REQ, 4, number of requesters (2..8)
BUSY_TMO, 16, cycles to wait for i_utx_busy to rise after a start pulse
LOCK_TMO, 1024, idle cycles a locked owner may go without valid before its lock is dropped

Ports:
i_clk  in  1  system clock
i_arst_n  in  1  asynchronous active-low reset
iv_req_valid  in  N_REQ  per-requester byte valid
iv_req_data  in  8*N_REQ  per-requester byte; requester k uses bits [8k+7:8k]
iv_req_last  in  N_REQ  byte is the last of its packet
ov_req_ack  out  N_REQ  one-cycle pulse: byte consumed
o_utx_start  out  1  one-cycle start pulse to UART TX
ov_utx_data  out  8  byte to UART TX
i_utx_busy  in  1  UART TX busy
ov_grant  out  N_REQ  one-hot current owner; 0 when no owner
o_locked  out  1  packet lock held
o_busy_tmo  out  1  pulse: busy never rose
o_lock_drop  out  1  pulse: lock released by LOCK_TMO

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM=IDLE, RR pointer=0, timers=0.
- States: IDLE, START, WAIT_HI, WAIT_LO.
- IDLE, no arbitration while i_utx_busy=1.
- IDLE, locked:
  - Owner valid=1 → capture owner byte into ov_utx_data, latch last flag, go to START.
  - Owner valid=0 → lock timer increments.
  - Timer reaches LOCK_TMO-1 → clear lock and ov_grant, pulse o_lock_drop, set pointer = owner+1 mod N_REQ, reset timer.
- IDLE, unlocked:
  - Pick the first valid requester searching from the pointer upward, wrapping.
  - Set ov_grant, set o_locked, capture byte, go to START.
  - No valid requester → stay in IDLE.
- START (exactly 1 cycle):
  - o_utx_start=1 and ov_req_ack[owner]=1 in this cycle.
  - Requester holds valid/data stable until it sees ack and may change them on the next edge.
  - Go to WAIT_HI, clear busy timer.
- WAIT_HI:
  - i_utx_busy=1 → go to WAIT_LO.
  - Busy timer reaches BUSY_TMO-1 → pulse o_busy_tmo, release lock, clear ov_grant, advance pointer to owner+1, go to IDLE.
  - The byte is counted as consumed; no retry.
- WAIT_LO: i_utx_busy=0 → go to IDLE.
  - If the latched last flag=1, release lock, clear ov_grant, set pointer = owner+1.
  - Otherwise keep the lock.
- ov_utx_data holds stable from START until the next capture.
- Latency: valid in IDLE (busy=0) → o_utx_start 1 cycle later. Minimum inter-byte gap = start + busy period + 1 IDLE cycle.
- Simultaneous events:
  - A valid from a non-owner while locked is ignored.
  - The owner raising valid in the same cycle LOCK_TMO expires: send wins, no drop.
  - The pointer only updates on lock release.
- Single-byte packet (valid+last together): the lock is taken and released around that one byte.
- Reset mid-operation: FSM returns to IDLE, lock cleared, no start/ack pulse emitted. A requester whose byte was not yet acked must re-present it.

Test Plan:
1. Req0 sends 3 bytes 0x41, 0x42, 0x43 (last on 0x43); UART model busy 1 cycle after start for 10 cycles → three start pulses, data in order, three acks to req0, o_locked falls after the third busy fall, ov_grant returns to 0.
2. Req1 and req2 both valid with 2-byte packets, pointer=0 → req1's packet completes in full (no interleaving), then req2 is granted, then the pointer equals 3.
3. Req3 locked after a non-last byte, then valid held low for LOCK_TMO=1024 cycles while req0 is valid → o_lock_drop pulses at cycle 1024, then req0 is granted next.
4. UART model never asserts busy → o_busy_tmo pulses 16 cycles after the start, lock released, the next requester is served.
5. i_utx_busy held high externally (CPU write) while req0 is valid → no start until busy falls, then start 1 cycle later.
6. i_arst_n asserted during WAIT_LO of a locked packet → all outputs 0 immediately; after release, req valid gives a grant from pointer 0.
